// File: rtl/binary2bcd_seq_ctrl_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// controller state encoding, default operand/result sizes and the
// double-dabble correction threshold.
package binary2bcd_seq_ctrl_pkg;

    // Controller states: waiting for an operand, iterating, holding a result
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Default binary operand width and matching number of BCD digits
    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_DIGITS = 3;

    // A BCD digit at or above this value gets +3 before the shift so that
    // doubling it carries correctly into the next decade
    localparam logic [3:0] ADJUST_THRESHOLD = 4'd5;
    localparam logic [3:0] ADJUST_OFFSET    = 4'd3;

endpackage : binary2bcd_seq_ctrl_pkg

// File: rtl/binary2bcd_seq_ctrl_bcd_digit_adjust.sv
// Single-digit double-dabble correction: adds 3 to a BCD digit that is
// 5 or more, passes smaller digits through unchanged. Purely combinational.
module bcd_digit_adjust
    import binary2bcd_seq_ctrl_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Conditional +3 correction ahead of the left shift
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= ADJUST_THRESHOLD) begin
            digit_out = digit_in + ADJUST_OFFSET;
        end
    end

endmodule : bcd_digit_adjust

// File: rtl/binary2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter using the double-dabble algorithm.
// One iteration per clock: an operand accepted in IDLE is shifted through a
// combined {BCD, binary} register for WIDTH cycles, then the packed BCD
// result is held in DONE until the consumer takes it.
module binary2bcd_seq_ctrl
    import binary2bcd_seq_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_binary,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DIGITS*4-1:0] packed_bcd,
    output logic                busy
);

    localparam int BCD_W = DIGITS * 4;
    localparam int TOT_W = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   iter_cnt;
    logic [BCD_W-1:0]   bcd_reg;
    logic [WIDTH-1:0]   bin_reg;

    logic [BCD_W-1:0]   adj_bcd;
    logic [TOT_W-1:0]   work;
    logic [TOT_W-1:0]   shifted;

    // One correction unit per BCD digit of the working register
    for (genvar d = 0; d < DIGITS; d++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .digit_in  (bcd_reg[d*4 +: 4]),
            .digit_out (adj_bcd[d*4 +: 4])
        );
    end

    // Corrected digits concatenated with the remaining binary bits, then shifted
    // left as a single vector so the binary MSB falls into the BCD LSB
    always_comb begin
        work    = {adj_bcd, bin_reg};
        shifted = work << 1;
    end

    // Controller, iteration counter, shift register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            iter_cnt   <= '0;
            bcd_reg    <= '0;
            bin_reg    <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            packed_bcd <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_reg  <= in_binary;
                        bcd_reg  <= '0;
                        iter_cnt <= '0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                SHIFT: begin
                    bcd_reg  <= shifted[TOT_W-1:WIDTH];
                    bin_reg  <= shifted[WIDTH-1:0];
                    iter_cnt <= iter_cnt + 1'b1;
                    // The result is published straight from the final shift so
                    // out_valid and packed_bcd rise together on the last edge
                    if (iter_cnt == LAST_ITER) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        packed_bcd <= shifted[TOT_W-1:WIDTH];
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state      <= IDLE;
                        out_valid  <= 1'b0;
                        packed_bcd <= '0;
                        busy       <= 1'b0;
                        in_ready   <= 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    iter_cnt   <= '0;
                    bcd_reg    <= '0;
                    bin_reg    <= '0;
                    in_ready   <= 1'b1;
                    out_valid  <= 1'b0;
                    busy       <= 1'b0;
                    packed_bcd <= '0;
                end
            endcase
        end
    end

endmodule : binary2bcd_seq_ctrl
